seq_block_adder: RTL and testbench
==================================

// Module: seq_block_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder built around one 4-bit carry look-ahead slice.
//   - Processes one nibble per clock, LSB nibble first.
//   - A registered carry links successive nibbles.
//   - Also reports word-level block propagate (AND of all nibble PP).
//   - Consumes operands from a valid/ready source; presents the result on a valid/ready sink.
// PARAMETERS
//   WIDTH  16  operand/sum width; must be a multiple of 4 and >= 8
//   NIB    WIDTH/4  derived localparam: nibble count; not overridable
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      operands a, b, c_in valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  addend
//   b          in   WIDTH  addend
//   c_in       in   1      word carry-in
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      sink accepts result
//   s          out  WIDTH  sum
//   c_out      out  1      carry out of the MSB nibble
//   all_prop   out  1      1 when every bit position propagates (a^b == all ones)
// BEHAVIOUR
//   Reset values
//   - rst=1 asynchronously forces state IDLE.
//   - Outputs: s=0, c_out=0, all_prop=0, out_valid=0, in_ready=1.
//   - Internal state: nibble index=0, carry reg=0, operand regs=0.
//   FSM states: IDLE, RUN, DONE
//   - IDLE: in_ready=1. On in_valid=1, latch a, b, c_in; carry reg<=c_in; idx<=0; go to RUN.
//   - RUN: in_ready=0. Each cycle, slice k=idx adds a[4k+3:4k] + b[4k+3:4k] + carry reg.
//     - Write slice sum into s[4k+3:4k].
//     - carry reg <= slice carry-out (G|P&cin form).
//     - all_prop accumulator <= acc & PP (acc starts at 1).
//     - idx<=idx+1. When idx==NIB-1: c_out<=slice carry-out, go to DONE.
//   - DONE: out_valid=1. s, c_out and all_prop stay stable until handshake.
//     - On out_ready=1, go to IDLE the next cycle.
//     - in_ready stays 0 during DONE.
//   Timing
//   - Latency: operands accepted at edge t; out_valid rises after edge t+NIB.
//   - Throughput: one result per NIB+2 cycles minimum.
//   Boundary conditions
//   - in_valid while busy (RUN/DONE) is ignored; the source must hold its data.
//   - s is partially written during RUN. It is only defined while out_valid=1.
//   - Word-level arithmetic is unsigned modulo 2^WIDTH; c_out is the carry-out bit.
//   - An operand change after acceptance has no effect on the result.
//   - rst asserted mid-RUN or in DONE aborts: state IDLE, result discarded.
// CONFIGURATION
//   Macro SEQ_ADD_OVF_EN
//   - Defined: adds output port ovf (out, 1).
//     - ovf = carry into bit WIDTH-1 XOR c_out (two's-complement overflow).
//     - Registered with c_out, valid with out_valid, reset 0.
//   - Undefined: no ovf port and no related logic. All other behaviour is identical.
// STRUCTURE
//   Package seq_add_pkg holds:
//   - FSM state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//   - Function clog2 for sizing the nibble index.
//   Sub-module cla_nibble_slice
//   - Combinational 4-bit CLA slice.
//   - Ports: a[3:0], b[3:0], cin in; s[3:0], pp, gg, cout out.
//   - One instance, muxed by idx.
// TESTING  (WIDTH=16, unless noted)
//   - 0x1234+0x4321, c_in=0 -> s=0x5555, c_out=0, all_prop=0; out_valid 4 cycles after accept.
//   - 0xFFFF+0x0001, c_in=0 -> s=0x0000, c_out=1; carry ripples through all 4 nibbles.
//   - 0xF0F0+0x0F0F, c_in=1 -> s=0x0000, c_out=1, all_prop=1; with c_in=0 -> s=0xFFFF, c_out=0.
//   - Backpressure: hold out_ready=0 for 5 cycles -> s, c_out and out_valid stable.
//     - in_ready stays 0; pulsing in_valid gives no new accept.
//   - Reset: assert rst during the 2nd RUN cycle -> immediate IDLE, all outputs 0.
//     - Next operands 0x0001+0x0001 -> s=0x0002.
//   - SEQ_ADD_OVF_EN defined: 0x8000+0x8000 -> s=0x0000, c_out=1, ovf=1.
//     - 0x7FFF+0x0001 -> s=0x8000, c_out=0, ovf=1.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and an index-sizing helper.
package seq_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry look-ahead slice with group propagate/generate outputs.
module cla_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pp,
  output logic       gg,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pp   = &p;
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cout = gg | (pp & cin);
  assign s    = p ^ c;

endmodule

// File: rtl/seq_block_adder.sv
// WIDTH-bit adder that reuses one CLA nibble slice per clock, LSB nibble first.
// Defining SEQ_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).
module seq_block_adder
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
`ifdef SEQ_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             all_prop
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (clog2(NIB) < 1) ? 1 : clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d;
  logic             acc_q, acc_d;
  logic             c_out_q, c_out_d;
  logic             all_prop_q, all_prop_d;
`ifdef SEQ_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0] sl_a, sl_b, sl_s;
  logic       sl_pp, sl_gg, sl_cout, sl_c_next;

  assign sl_a      = a_q[{idx_q, 2'b00} +: 4];
  assign sl_b      = b_q[{idx_q, 2'b00} +: 4];
  assign sl_c_next = sl_gg | (sl_pp & carry_q);

  cla_nibble_slice u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .s   (sl_s),
    .pp  (sl_pp),
    .gg  (sl_gg),
    .cout(sl_cout)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    s_d        = s_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    c_out_d    = c_out_q;
    all_prop_d = all_prop_q;
`ifdef SEQ_ADD_OVF_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          acc_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_d[{idx_q, 2'b00} +: 4] = sl_s;
        carry_d = sl_c_next;
        acc_d   = acc_q & sl_pp;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          c_out_d    = sl_cout;
          all_prop_d = acc_q & sl_pp;
`ifdef SEQ_ADD_OVF_EN
          // carry into the MSB is recovered from its sum bit and operand bits
          ovf_d      = (sl_s[3] ^ sl_a[3] ^ sl_b[3]) ^ sl_cout;
`endif
          state_d    = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      carry_q    <= 1'b0;
      acc_q      <= 1'b0;
      c_out_q    <= 1'b0;
      all_prop_q <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s_q        <= s_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      c_out_q    <= c_out_d;
      all_prop_q <= all_prop_d;
`ifdef SEQ_ADD_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign all_prop  = all_prop_q;
`ifdef SEQ_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_block_adder.sv
// Scoreboard bench for seq_block_adder (WIDTH=16); expected results come from a behavioural model.
module tb_seq_block_adder;

  localparam int W = 16;
`ifdef SEQ_ADD_OVF_EN
  localparam bit HAS_OVF = 1'b1;
`else
  localparam bit HAS_OVF = 1'b0;
`endif

  typedef logic [W+2:0] res_t;  // {ovf, c_out, all_prop, s}

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         c;
    logic         ap;
  } vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, all_prop;
  logic [W-1:0] a, b, s;
`ifdef SEQ_ADD_OVF_EN
  logic ovf;
`endif

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;
  time  t_acc = 0;

  seq_block_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .c_out    (c_out),
`ifdef SEQ_ADD_OVF_EN
    .ovf      (ovf),
`endif
    .all_prop (all_prop)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] sum;
    logic       v;
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v   = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    return {(HAS_OVF ? v : 1'b0), sum[W], &(x ^ y), sum[W-1:0]};
  endfunction

  function automatic res_t observed();
`ifdef SEQ_ADD_OVF_EN
    return {ovf, c_out, all_prop, s};
`else
    return {1'b0, c_out, all_prop, s};
`endif
  endfunction

  // Offer operands, wait for acceptance, push the model result at the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; c_in = ci;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    if (in_ready) begin
      sb.push_back(model(x, y, ci));
      t_acc = $time;
    end
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, res_t'(0)}) begin
      bad++;
      $display("FAIL reset_values: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0", out_valid, in_ready, observed());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t vt[6];
    int   n;
    res_t e;
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b1};
    vt[3] = '{16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send(vt[i].a, vt[i].b, vt[i].ci);
      wait_valid(n);
      total++;
      if (n !== 4) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d cycles want 4", i, n);
      end
      total++;
      if ({c_out, all_prop, s} !== {vt[i].c, vt[i].ap, vt[i].s}) begin
        bad++;
        $display("FAIL directed_const[%0d]: got c=%b ap=%b s=%h want c=%b ap=%b s=%h",
                 i, c_out, all_prop, s, vt[i].c, vt[i].ap, vt[i].s);
      end
      e = sb.pop_front();
      total++;
      if (observed() !== e) begin
        bad++;
        $display("FAIL directed_sb[%0d]: got %h want %h", i, observed(), e);
      end
      ack();
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL directed_release[%0d]: got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int   n;
    res_t e, snap;
    send(16'hABCD, 16'h1111, 1'b0);
    wait_valid(n);
    e = sb.pop_front();
    snap = observed();
    total++;
    if (snap !== e) begin
      bad++;
      $display("FAIL bp_result: got %h want %h", snap, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, e}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                 i, out_valid, in_ready, observed(), e);
      end
    end
    in_valid = 1'b0;
    ack();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_midrun_reset();
    int   n;
    res_t e;
    send(16'h1234, 16'h0FF0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, res_t'(0)}) begin
      bad++;
      $display("FAIL midrun_reset: got ov=%b ir=%b res=%h want ov=0 ir=1 res=0", out_valid, in_ready, observed());
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    send(16'h0001, 16'h0001, 1'b0);
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if ({s, observed()} !== {16'h0002, e}) begin
      bad++;
      $display("FAIL after_reset: got s=%h res=%h want s=0002 res=%h n=%0d", s, observed(), e, n);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    int   n;
    time  prev;
    res_t e;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      if (i > 0) begin
        total++;
        if (t_acc - prev !== 60) begin
          bad++;
          $display("FAIL b2b_period[%0d]: got %0t want 60", i, t_acc - prev);
        end
      end
      prev = t_acc;
      wait_valid(n);
      e = sb.pop_front();
      total++;
      if (observed() !== e || n !== 4) begin
        bad++;
        $display("FAIL b2b_result[%0d]: got %h n=%0d want %h n=4", i, observed(), n, e);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int   n;
    res_t e;
    for (int i = 0; i < 12; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      wait_valid(n);
      e = sb.pop_front();
      total++;
      if (observed() !== e || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL random[%0d]: got %h ov=%b want %h ov=1", i, observed(), out_valid, e);
      end
      ack();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
